debug_mem_bridge: RTL and testbench

- Synthesizable host-side driver for the core's BRAM debug ports (CPU_Debug_DataRAM_* / CPU_Debug_InstRAM_*: A2, WD2, WE2, RD2).
- Lets a byte-stream host, typically a UART receiver/transmitter pair, load instruction and data RAM, dump them, and hold or release the core's reset.
- Sits between the board-level serial blocks and RV32Core.

---
 rtl/debug_mem_bridge_if.sv | 40 ++++
 rtl/debug_mem_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_debug_mem_bridge.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_mem_bridge_if.sv
// Byte-stream host link plus the two BRAM debug ports of RV32Core.
//
// Signals:
//   rx_valid/rx_data/rx_ready : host -> bridge command stream
//   tx_valid/tx_data/tx_ready : bridge -> host response stream
//   dbg_dram_* / dbg_iram_*   : A2/WD2/WE2 toward the RAMs, RD2 back from them
//
// Modports:
//   master : the bridge side
//   slave  : the host/RAM side
interface debug_mem_bridge_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [31:0] dbg_dram_a2;
    logic [31:0] dbg_dram_wd2;
    logic [3:0]  dbg_dram_we2;
    logic [31:0] dbg_dram_rd2;
    logic [31:0] dbg_iram_a2;
    logic [31:0] dbg_iram_wd2;
    logic [3:0]  dbg_iram_we2;
    logic [31:0] dbg_iram_rd2;

    modport master (
        input  rx_valid, rx_data, tx_ready, dbg_dram_rd2, dbg_iram_rd2,
        output rx_ready, tx_valid, tx_data,
               dbg_dram_a2, dbg_dram_wd2, dbg_dram_we2,
               dbg_iram_a2, dbg_iram_wd2, dbg_iram_we2
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, dbg_dram_rd2, dbg_iram_rd2,
        input  rx_ready, tx_valid, tx_data,
               dbg_dram_a2, dbg_dram_wd2, dbg_dram_we2,
               dbg_iram_a2, dbg_iram_wd2, dbg_iram_we2
    );
endinterface

// File: rtl/debug_mem_bridge.sv
// Host-side debug bridge for RV32Core: decodes a little-endian byte-stream
// command protocol into writes/reads on the instruction and data BRAM debug
// ports, streams read data back LSB first, and holds/releases the core reset.
//
// Ports:
//   CPU_CLK     : core clock, all logic on the rising edge
//   CPU_RST_N   : asynchronous active-low reset
//   bus         : host byte streams and both BRAM debug ports (master side)
//   cpu_rst     : active-high reset to the core, set while in reset
//   bad_cmd_cnt : saturating count of unknown command bytes
//
// Commands: 0x57/0x77 write DRAM/IRAM (4 addr + 4 data bytes),
//           0x52/0x72 read DRAM/IRAM (4 addr bytes), 0x53 start, 0x48 halt.
module debug_mem_bridge #(
    parameter int READ_LATENCY   = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               CPU_CLK,
    input  logic               CPU_RST_N,
    debug_mem_bridge_if.master bus,
    output logic               cpu_rst,
    output logic [7:0]         bad_cmd_cnt
);
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] RD_LAST = 3'(READ_LATENCY - 1);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    localparam logic [7:0] CMD_DWR   = 8'h57;
    localparam logic [7:0] CMD_IWR   = 8'h77;
    localparam logic [7:0] CMD_DRD   = 8'h52;
    localparam logic [7:0] CMD_IRD   = 8'h72;
    localparam logic [7:0] CMD_START = 8'h53;
    localparam logic [7:0] CMD_HALT  = 8'h48;

    typedef enum logic [2:0] {
        IDLE, ADDR, DATA, WRITE, RD_WAIT, RD_SEND
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              cmd_wr, cmd_iram;
    logic              rx_ready_q, rx_ready_nxt;
    logic [31:0]       addr_q, data_q, addr_nxt, data_nxt, rd_sh;
    logic              rx_acc, tx_acc, in_frame, stalled, tmo_hit;
    logic              cap_cmd, set_run, set_halt, bad_cmd;
    logic              do_read, do_write, do_capture, do_shift;

    assign rx_acc   = bus.rx_valid && rx_ready_q;
    assign tx_acc   = (state == RD_SEND) && bus.tx_ready;
    assign in_frame = (state == ADDR) || (state == DATA);
    assign stalled  = in_frame && !rx_acc;
    assign tmo_hit  = stalled && (tmo_cnt == TMO_LAST);

    // Fields arrive LSB first, so each new byte enters at the top.
    assign addr_nxt = {bus.rx_data, addr_q[31:8]};
    assign data_nxt = {bus.rx_data, data_q[31:8]};

    assign bus.rx_ready = rx_ready_q;
    assign bus.tx_valid = (state == RD_SEND);
    assign bus.tx_data  = rd_sh[7:0];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cap_cmd    = 1'b0;
        set_run    = 1'b0;
        set_halt   = 1'b0;
        bad_cmd    = 1'b0;
        do_read    = 1'b0;
        do_write   = 1'b0;
        do_capture = 1'b0;
        do_shift   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_acc) begin
                    case (bus.rx_data)
                        CMD_DWR, CMD_IWR, CMD_DRD, CMD_IRD: begin
                            cap_cmd   = 1'b1;
                            cnt_nxt   = 3'd0;
                            state_nxt = ADDR;
                        end
                        CMD_START: set_run  = 1'b1;
                        CMD_HALT:  set_halt = 1'b1;
                        default:   bad_cmd  = 1'b1;
                    endcase
                end
            end
            ADDR: begin
                if (rx_acc) begin
                    cnt_nxt = cnt + 3'd1;
                    if (cnt == 3'd3) begin
                        cnt_nxt = 3'd0;
                        if (cmd_wr) begin
                            state_nxt = DATA;
                        end else begin
                            do_read   = 1'b1;
                            state_nxt = RD_WAIT;
                        end
                    end
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            DATA: begin
                if (rx_acc) begin
                    cnt_nxt = cnt + 3'd1;
                    if (cnt == 3'd3) begin
                        cnt_nxt   = 3'd0;
                        do_write  = 1'b1;
                        state_nxt = WRITE;
                    end
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            WRITE: state_nxt = IDLE;
            RD_WAIT: begin
                // A2 was launched on entry; RD2 is valid on the last wait cycle.
                if (cnt == RD_LAST) begin
                    do_capture = 1'b1;
                    cnt_nxt    = 3'd0;
                    state_nxt  = RD_SEND;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            RD_SEND: begin
                if (tx_acc) begin
                    do_shift = 1'b1;
                    cnt_nxt  = cnt + 3'd1;
                    if (cnt == 3'd3) begin
                        cnt_nxt   = 3'd0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Registered so that rx_ready is 0 while reset is asserted.
        rx_ready_nxt = (state_nxt == IDLE) || (state_nxt == ADDR) || (state_nxt == DATA);
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            tmo_cnt    <= '0;
            rx_ready_q <= 1'b0;
            cmd_wr     <= 1'b0;
            cmd_iram   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rx_ready_q <= rx_ready_nxt;
            tmo_cnt    <= stalled ? tmo_cnt + TMO_W'(1) : '0;
            if (cap_cmd) begin
                cmd_wr   <= (bus.rx_data == CMD_DWR) || (bus.rx_data == CMD_IWR);
                cmd_iram <= (bus.rx_data == CMD_IWR) || (bus.rx_data == CMD_IRD);
            end
        end
    end

    // Frame assembly registers are fully overwritten before every use.
    always_ff @(posedge CPU_CLK) begin
        if (rx_acc && (state == ADDR)) addr_q <= addr_nxt;
        if (rx_acc && (state == DATA)) data_q <= data_nxt;
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            cpu_rst          <= 1'b1;
            bad_cmd_cnt      <= 8'd0;
            bus.dbg_dram_a2  <= 32'd0;
            bus.dbg_dram_wd2 <= 32'd0;
            bus.dbg_dram_we2 <= 4'd0;
            bus.dbg_iram_a2  <= 32'd0;
            bus.dbg_iram_wd2 <= 32'd0;
            bus.dbg_iram_we2 <= 4'd0;
            rd_sh            <= 32'd0;
        end else begin
            if (set_run) begin
                cpu_rst <= 1'b0;
            end else if (set_halt) begin
                cpu_rst <= 1'b1;
            end
            if (bad_cmd) begin
                bad_cmd_cnt <= sat_inc8(bad_cmd_cnt);
            end
            // WE2 is a single-cycle pulse; A2/WD2 keep their last values.
            bus.dbg_dram_we2 <= 4'd0;
            bus.dbg_iram_we2 <= 4'd0;
            if (do_write) begin
                if (cmd_iram) begin
                    bus.dbg_iram_a2  <= addr_q & WORD_MASK;
                    bus.dbg_iram_wd2 <= data_nxt;
                    bus.dbg_iram_we2 <= 4'hF;
                end else begin
                    bus.dbg_dram_a2  <= addr_q & WORD_MASK;
                    bus.dbg_dram_wd2 <= data_nxt;
                    bus.dbg_dram_we2 <= 4'hF;
                end
            end
            if (do_read) begin
                if (cmd_iram) begin
                    bus.dbg_iram_a2 <= addr_nxt & WORD_MASK;
                end else begin
                    bus.dbg_dram_a2 <= addr_nxt & WORD_MASK;
                end
            end
            if (do_capture) begin
                rd_sh <= cmd_iram ? bus.dbg_iram_rd2 : bus.dbg_dram_rd2;
            end else if (do_shift) begin
                rd_sh <= {8'h00, rd_sh[31:8]};
            end
        end
    end
endmodule

// File: tb/tb_debug_mem_bridge.sv
module tb_debug_mem_bridge;
    localparam int RL = 2;
    localparam int TL = 64;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_rst;
    logic [7:0] bad_cmd_cnt;

    debug_mem_bridge_if bus();

    debug_mem_bridge #(
        .READ_LATENCY   (RL),
        .TIMEOUT_CYCLES (TL)
    ) dut (
        .CPU_CLK     (clk),
        .CPU_RST_N   (rst_n),
        .bus         (bus),
        .cpu_rst     (cpu_rst),
        .bad_cmd_cnt (bad_cmd_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // BRAM models: synchronous write, one-register read path.
    bit [31:0] dmem [256];
    bit [31:0] imem [256];
    always @(posedge clk) begin
        if (bus.dbg_dram_we2 == 4'hF) dmem[bus.dbg_dram_a2[9:2]] <= bus.dbg_dram_wd2;
        if (bus.dbg_iram_we2 == 4'hF) imem[bus.dbg_iram_a2[9:2]] <= bus.dbg_iram_wd2;
        bus.dbg_dram_rd2 <= dmem[bus.dbg_dram_a2[9:2]];
        bus.dbg_iram_rd2 <= imem[bus.dbg_iram_a2[9:2]];
    end

    // Every cycle with a nonzero WE2 is logged as a write event.
    typedef struct {
        bit          iram;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  we;
    } wev_t;
    wev_t wq[$];
    int   both_we = 0;
    always @(negedge clk) begin
        if (bus.dbg_dram_we2 != 4'h0) wq.push_back('{1'b0, bus.dbg_dram_a2, bus.dbg_dram_wd2, bus.dbg_dram_we2});
        if (bus.dbg_iram_we2 != 4'h0) wq.push_back('{1'b1, bus.dbg_iram_a2, bus.dbg_iram_wd2, bus.dbg_iram_we2});
        if ((bus.dbg_dram_we2 != 4'h0) && (bus.dbg_iram_we2 != 4'h0)) both_we++;
    end

    // Reference model: memory images and control state by protocol rules.
    bit [31:0] ref_d [256];
    bit [31:0] ref_i [256];
    bit        cpu_rst_m = 1'b1;
    int        bad_m = 0;

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        n = 0;
        while (!bus.rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rx_ready) check_val("rx_ready_wait", 32'(bus.rx_ready), 1);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic write_frame(input bit iram, input logic [31:0] addr, input logic [31:0] data,
                               input int gap_pos, input int gap_len);
        logic [7:0] fr [9];
        int base;
        base  = wq.size();
        fr[0] = iram ? 8'h77 : 8'h57;
        for (int i = 0; i < 4; i++) fr[1+i] = addr[8*i +: 8];
        for (int i = 0; i < 4; i++) fr[5+i] = data[8*i +: 8];
        for (int i = 0; i < 9; i++) send_byte(fr[i], (i == gap_pos) ? gap_len : $urandom_range(0, 2));
        if (iram) ref_i[addr[9:2]] = data;
        else      ref_d[addr[9:2]] = data;
        repeat (3) @(negedge clk);
        check_val("wr_events", wq.size() - base, 1);
        if (wq.size() > base) begin
            check_val("wr_ram", 32'(wq[base].iram), 32'(iram));
            check_val("wr_a2", wq[base].a, addr & 32'hFFFF_FFFC);
            check_val("wr_wd2", wq[base].d, data);
            check_val("wr_we2", 32'(wq[base].we), 32'hF);
        end
    endtask

    task automatic read_frame(input bit iram, input logic [31:0] addr, input int sb, input int sn);
        logic [31:0] exp;
        int n, base;
        base = wq.size();
        exp  = iram ? ref_i[addr[9:2]] : ref_d[addr[9:2]];
        send_byte(iram ? 8'h72 : 8'h52, $urandom_range(0, 2));
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], $urandom_range(0, 2));
        check_val("rd_a2", iram ? bus.dbg_iram_a2 : bus.dbg_dram_a2, addr & 32'hFFFF_FFFC);
        n = 0;
        while (!bus.tx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("rd_latency", n, RL);
        for (int i = 0; i < 4; i++) begin
            if (i == sb) begin
                for (int k = 0; k < sn; k++) begin
                    check_val("rd_hold", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, exp[8*i +: 8]});
                    check_val("rd_busy", 32'(bus.rx_ready), 0);
                    @(negedge clk);
                end
            end
            check_val("rd_byte", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, exp[8*i +: 8]});
            bus.tx_ready = 1'b1;
            @(negedge clk);
            bus.tx_ready = 1'b0;
        end
        check_val("rd_end_valid", 32'(bus.tx_valid), 0);
        check_val("rd_end_ready", 32'(bus.rx_ready), 1);
        check_val("rd_no_write", wq.size() - base, 0);
    endtask

    task automatic ctrl_byte(input logic [7:0] b);
        send_byte(b, $urandom_range(0, 2));
        if (b == 8'h53)      cpu_rst_m = 1'b0;
        else if (b == 8'h48) cpu_rst_m = 1'b1;
        else                 bad_m = (bad_m < 255) ? bad_m + 1 : 255;
        check_val("cpu_rst", 32'(cpu_rst), 32'(cpu_rst_m));
        check_val("bad_cnt", 32'(bad_cmd_cnt), bad_m);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;

        // Power-on reset values
        repeat (3) @(negedge clk);
        check_val("rst_rx_ready", 32'(bus.rx_ready), 0);
        check_val("rst_cpu_rst", 32'(cpu_rst), 1);
        check_val("rst_tx_valid", 32'(bus.tx_valid), 0);
        check_val("rst_bad", 32'(bad_cmd_cnt), 0);
        check_val("rst_dwe", 32'(bus.dbg_dram_we2), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rel_rx_ready", 32'(bus.rx_ready), 1);

        // Directed DRAM write
        write_frame(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, -1, 0);

        // Start / halt
        ctrl_byte(8'h53);
        ctrl_byte(8'h48);

        // IRAM preload and read with unaligned address and tx backpressure
        write_frame(1'b1, 32'h0000_0008, 32'h0050_0093, -1, 0);
        read_frame(1'b1, 32'h0000_000B, 1, 5);
        read_frame(1'b0, 32'h0000_0012, -1, 0);

        // Longest legal stall inside a frame
        write_frame(1'b0, 32'h0000_0020, 32'h1234_5678, 2, TL - 1);
        read_frame(1'b0, 32'h0000_0020, -1, 0);

        // Frame abandoned mid-address is dropped without a write
        base = wq.size();
        send_byte(8'h57, 0);
        send_byte(8'h10, 0);
        repeat (TL + 3) @(negedge clk);
        check_val("tmo_no_write", wq.size() - base, 0);
        check_val("tmo_bad_cnt", 32'(bad_cmd_cnt), bad_m);
        write_frame(1'b0, 32'h0000_0010, 32'hCAFE_F00D, -1, 0);
        read_frame(1'b0, 32'h0000_0010, -1, 0);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            int op;
            logic [31:0] r, a, d;
            logic [7:0] b;
            bit ir;
            op = $urandom_range(0, 9);
            r  = $urandom();
            a  = r & 32'hF000_003F;
            d  = $urandom();
            ir = 1'($urandom_range(0, 1));
            if (op < 4) begin
                write_frame(ir, a, d, -1, 0);
            end else if (op < 8) begin
                read_frame(ir, a, $urandom_range(0, 4), $urandom_range(0, 4));
            end else if (op == 8) begin
                ctrl_byte(($urandom_range(0, 1) == 1) ? 8'h53 : 8'h48);
            end else begin
                b = 8'(($urandom_range(0, 255)));
                while (b == 8'h57 || b == 8'h77 || b == 8'h52 || b == 8'h72 || b == 8'h53 || b == 8'h48)
                    b = 8'(($urandom_range(0, 255)));
                ctrl_byte(b);
            end
        end

        // Saturation of the bad command counter
        for (int i = 0; i < 300; i++) begin
            send_byte(8'hAA, 0);
            bad_m = (bad_m < 255) ? bad_m + 1 : 255;
        end
        check_val("bad_sat", 32'(bad_cmd_cnt), 255);
        ctrl_byte(8'h53);

        // Asynchronous reset in the middle of a response
        send_byte(8'h52, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        n = 0;
        while (!bus.tx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("mid_tx_valid", 32'(bus.tx_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_tx_valid", 32'(bus.tx_valid), 0);
        check_val("arst_cpu_rst", 32'(cpu_rst), 1);
        check_val("arst_rx_ready", 32'(bus.rx_ready), 0);
        check_val("arst_bad", 32'(bad_cmd_cnt), 0);
        check_val("arst_da2", bus.dbg_dram_a2, 0);
        check_val("arst_tx_data", 32'(bus.tx_data), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cpu_rst_m = 1'b1;
        bad_m = 0;
        @(negedge clk);
        check_val("arel_rx_ready", 32'(bus.rx_ready), 1);
        check_val("arel_bad", 32'(bad_cmd_cnt), 0);
        check_val("arel_cpu_rst", 32'(cpu_rst), 1);

        // Normal operation after reset
        write_frame(1'b1, 32'h0000_0030, 32'hA5A5_0F0F, -1, 0);
        read_frame(1'b1, 32'h0000_0030, 3, 2);
        check_val("both_we", both_we, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
